// File: rtl/l2_bus_req_queue.sv
// Bounded in-order queue of L2 line operations toward the memory bus, with write merge and HITM snooping.
// Optional per-op issue counters are built when BUSQ_STATS_EN is defined.
module l2_bus_req_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     bus_valid,
  input  logic                     bus_ack,
  output logic [1:0]               bus_op,
  output logic [ADDR_W-1:0]        bus_addr,
  input  logic                     snoop_valid,
  input  logic [ADDR_W-1:0]        snoop_addr,
  output logic                     snoop_hitm,
  output logic [$clog2(DEPTH):0]   count
`ifdef BUSQ_STATS_EN
  ,
  output logic [CNT_W-1:0]         cnt_read,
  output logic [CNT_W-1:0]         cnt_write,
  output logic [CNT_W-1:0]         cnt_rfo,
  output logic [CNT_W-1:0]         cnt_inval
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state_reg, state_next;

  logic [1:0]        op_mem   [DEPTH];
  logic [LINE_W-1:0] line_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [1:0]        bus_op_reg;
  logic [LINE_W-1:0] bus_line_reg;
  logic              hitm_reg;

  logic [LINE_W-1:0] req_line, snoop_line;
  logic [DEPTH-1:0]  merge_hit, snoop_hit;
  logic              full, empty, accept, merge, push, pop, load;
  logic              unused_offset_bits;

  assign req_line   = req_addr[ADDR_W-1:OFFSET_W];
  assign snoop_line = snoop_addr[ADDR_W-1:OFFSET_W];
  assign unused_offset_bits = ^{req_addr[OFFSET_W-1:0], snoop_addr[OFFSET_W-1:0]};

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // Per-entry occupancy derived from distance to the head, so no valid bits are needed.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
    logic [PTR_W-1:0] rel;
    logic             occupied, is_write, in_flight;

    assign rel       = IDX - rd_ptr_reg;
    assign occupied  = ({1'b0, rel} < count_reg);
    assign is_write  = occupied && (op_mem[gi] == OP_WRITE);
    assign in_flight = (state_reg == ISSUE) && (IDX == rd_ptr_reg);

    assign merge_hit[gi] = is_write && !in_flight && (line_mem[gi] == req_line);
    assign snoop_hit[gi] = is_write && (line_mem[gi] == snoop_line);
  end

  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign merge     = accept && (req_op == OP_WRITE) && (|merge_hit);
  assign push      = accept && !merge;
  assign pop       = (state_reg == ISSUE) && bus_ack;
  assign load      = (state_reg == IDLE) && !empty;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!empty) state_next = ISSUE;
      ISSUE:   if (bus_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      bus_op_reg   <= '0;
      bus_line_reg <= '0;
      hitm_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      hitm_reg  <= snoop_valid && (|snoop_hit);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (load) begin
        bus_op_reg   <= op_mem[rd_ptr_reg];
        bus_line_reg <= line_mem[rd_ptr_reg];
      end
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_reg]   <= req_op;
      line_mem[wr_ptr_reg] <= req_line;
    end
  end

  assign bus_valid  = (state_reg == ISSUE);
  assign bus_op     = bus_op_reg;
  assign bus_addr   = {bus_line_reg, {OFFSET_W{1'b0}}};
  assign snoop_hitm = hitm_reg;
  assign count      = count_reg;

`ifdef BUSQ_STATS_EN
  logic [CNT_W-1:0] stat_reg [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    localparam logic [1:0] OPC = 2'(gi);
    always_ff @(posedge clk) begin
      if (rst) begin
        stat_reg[gi] <= '0;
      end else if (pop && (bus_op_reg == OPC) && (stat_reg[gi] != '1)) begin
        stat_reg[gi] <= stat_reg[gi] + 1'b1;
      end
    end
  end

  assign cnt_read  = stat_reg[0];
  assign cnt_write = stat_reg[1];
  assign cnt_rfo   = stat_reg[2];
  assign cnt_inval = stat_reg[3];
`endif

endmodule
